// File: rtl/seq_shift_unit_if.sv
// seq_shift_unit_if
// Operand and result handshake bundle for the multi-cycle shift unit.
//   in_valid/in_ready : operand handshake (producer -> unit)
//   in_data           : 32-bit value to shift
//   in_shamt          : shift amount, 0..31
//   in_dir            : 0 = left, 1 = right
//   in_arith          : 1 = arithmetic right shift (ignored for left shifts)
//   out_valid/out_ready : result handshake (unit -> consumer)
//   out_data          : 32-bit shifted result
// Modports: master = pipeline side, slave = shift unit.
interface seq_shift_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_dir;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_dir, in_arith, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/seq_shift_unit.sv
// seq_shift_unit
// Area-reduced SLL/SRL/SRA unit: shifts a 32-bit operand by up to STEP bits
// per clock until the requested amount has been applied.
// Parameters:
//   STEP  : maximum shift distance per cycle (1, 2, 4 or 8)
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   flush : synchronous abort of any operation in progress
//   bus   : operand/result handshake (slave modport)
//   busy  : high while an operation is shifting or waiting to hand off
module seq_shift_unit #(
    parameter int unsigned STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    seq_shift_unit_if.slave   bus,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [4:0] STEP_W = 5'(STEP);

    state_e      state_q, state_d;
    logic [31:0] data_q,  data_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic        dir_q,   dir_d;
    logic        fill_q,  fill_d;

    logic        in_ready_s;
    logic        big_step_s;
    logic [4:0]  cnt_next_s;
    logic [31:0] shl_s;
    logic [31:0] shr_s;

    // Operand acceptance: only in IDLE, never while flushing or held in reset.
    always_comb begin
        in_ready_s = rst_n && (state_q == ST_IDLE) && !flush;
    end

    // Per-cycle shift step: a full STEP while enough distance remains, then single bits.
    always_comb begin
        big_step_s = (cnt_q >= STEP_W);
        if (big_step_s) begin
            cnt_next_s = cnt_q - STEP_W;
            shl_s      = data_q << STEP;
            // Inverting around the shift fills vacated MSBs with ones for SRA.
            if (fill_q) begin
                shr_s = ~((~data_q) >> STEP);
            end else begin
                shr_s = data_q >> STEP;
            end
        end else begin
            cnt_next_s = cnt_q - 5'd1;
            shl_s      = data_q << 1;
            if (fill_q) begin
                shr_s = ~((~data_q) >> 1);
            end else begin
                shr_s = data_q >> 1;
            end
        end
    end

    // Next-state and datapath update; flush overrides every state.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_s) begin
                        data_d = bus.in_data;
                        cnt_d  = bus.in_shamt;
                        dir_d  = bus.in_dir;
                        fill_d = bus.in_dir & bus.in_arith & bus.in_data[31];
                        if (bus.in_shamt == 5'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (dir_q) begin
                        data_d = shr_s;
                    end else begin
                        data_d = shl_s;
                    end
                    cnt_d = cnt_next_s;
                    if (cnt_next_s == 5'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= 32'd0;
            cnt_q   <= 5'd0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            fill_q  <= fill_d;
        end
    end

    // Outputs decode straight from registered state; out_data always shows the data register.
    always_comb begin
        bus.in_ready  = in_ready_s;
        bus.out_valid = (state_q == ST_DONE);
        bus.out_data  = data_q;
        busy          = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit
// Drives four seq_shift_unit instances (STEP = 1, 2, 4, 8) from one stimulus
// stream; sel picks which instance sees the handshake. A cycle-level
// reference tracks expected state and latency, and a scoreboard queue holds
// expected results pushed on accept and compared while out_valid is high.
module tb_seq_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_dir;
    logic        in_arith;
    logic        out_ready;
    logic [1:0]  sel;

    logic [3:0]  g_in_ready;
    logic [3:0]  g_out_valid;
    logic [3:0]  g_busy;
    logic [31:0] g_out_data [4];

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic        obs_busy;
    logic [31:0] obs_out_data;

    seq_shift_unit_if bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign bus[g].in_valid  = in_valid && (sel == 2'(g));
        assign bus[g].in_data   = in_data;
        assign bus[g].in_shamt  = in_shamt;
        assign bus[g].in_dir    = in_dir;
        assign bus[g].in_arith  = in_arith;
        assign bus[g].out_ready = out_ready && (sel == 2'(g));
        assign g_in_ready[g]    = bus[g].in_ready;
        assign g_out_valid[g]   = bus[g].out_valid;
        assign g_out_data[g]    = bus[g].out_data;

        seq_shift_unit #(.STEP(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .bus   (bus[g]),
            .busy  (g_busy[g])
        );
    end

    assign obs_in_ready  = g_in_ready[sel];
    assign obs_out_valid = g_out_valid[sel];
    assign obs_busy      = g_busy[sel];
    assign obs_out_data  = g_out_data[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mstate = 0;   // 0 idle, 1 shifting, 2 result held
    int          mrem   = 0;
    bit          accepted;
    logic [31:0] cur_exp;
    logic [4:0]  cur_shamt;
    logic [31:0] sb_q [$];
    logic [31:0] popped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int latency(input int n, input int step);
        return 1 + (n / step) + (n % step);
    endfunction

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic dr, input logic ar);
        logic signed [31:0] sd;
        sd = d;
        if (!dr)     return d << sh;
        else if (ar) return sd >>> sh;
        else         return d >> sh;
    endfunction

    // One clock: compare outputs against the reference, then advance it at the edge.
    task automatic tick();
        int L;
        #1;
        chk("in_ready", {31'd0, obs_in_ready}, {31'd0, (rst_n && mstate == 0 && !flush)});
        chk("out_valid", {31'd0, obs_out_valid}, {31'd0, (mstate == 2)});
        chk("busy", {31'd0, obs_busy}, {31'd0, (mstate != 0)});
        if (mstate == 2 && sb_q.size() > 0) chk("out_data", obs_out_data, sb_q[0]);
        @(posedge clk);
        if (!rst_n) begin
            mstate = 0;
            sb_q.delete();
        end else if (flush) begin
            if (mstate == 2 && out_ready && sb_q.size() > 0) popped = sb_q.pop_front();
            mstate = 0;
            sb_q.delete();
        end else begin
            case (mstate)
                0: if (in_valid) begin
                    sb_q.push_back(cur_exp);
                    accepted = 1'b1;
                    L = latency(int'(cur_shamt), 1 << sel);
                    if (L == 1) mstate = 2;
                    else begin
                        mstate = 1;
                        mrem   = L - 1;
                    end
                end
                1: begin
                    mrem--;
                    if (mrem == 0) mstate = 2;
                end
                2: if (out_ready) begin
                    popped = sb_q.pop_front();
                    mstate = 0;
                end
                default: mstate = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic dr,
                        input logic ar, input logic [31:0] exp, input bit rnd);
        in_data   = d;
        in_shamt  = sh;
        in_dir    = dr;
        in_arith  = ar;
        cur_exp   = exp;
        cur_shamt = sh;
        in_valid  = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 60 && !accepted; i++) begin
            if (rnd) flush = ($urandom_range(0, 99) < 2);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 150 && mstate != 0; i++) begin
            if (rnd) begin
                out_ready = ($urandom_range(0, 99) < 70);
                flush     = ($urandom_range(0, 99) < 2);
            end else begin
                out_ready = 1'b1;
            end
            tick();
        end
        flush = 1'b0;
        if (mstate != 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  rs;
        logic        rdir, rar;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        in_shamt = 5'd0; in_dir = 1'b0; in_arith = 1'b0; out_ready = 1'b1; sel = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_data", obs_out_data, 32'd0);
        chk("rst_out_valid", {31'd0, obs_out_valid}, 32'd0);
        chk("rst_busy", {31'd0, obs_busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // SLL by 31 with STEP = 1: 32-cycle latency, busy throughout.
        send(32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
        drain(1'b0);

        // Right shifts: sign fill versus zero fill.
        send(32'h8000_0000, 5'd4, 1'b1, 1'b1, 32'hF800_0000, 1'b0);
        drain(1'b0);
        send(32'h8000_0000, 5'd4, 1'b1, 1'b0, 32'h0800_0000, 1'b0);
        drain(1'b0);
        send(32'h7FFF_FFF0, 5'd4, 1'b1, 1'b1, 32'h07FF_FFFF, 1'b0);
        drain(1'b0);

        // Zero shift in both directions.
        send(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        drain(1'b0);
        send(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        drain(1'b0);

        // Backpressure: result held five cycles with out_ready low.
        out_ready = 1'b0;
        send(32'h1234_5678, 5'd3, 1'b0, 1'b0, 32'h91A2_B3C0, 1'b0);
        for (int i = 0; i < 40 && mstate != 2; i++) tick();
        chk("bp_reached_done", mstate, 32'd2);
        repeat (5) tick();
        drain(1'b0);
        tick();

        // Flush mid-shift, then a fresh operand.
        send(32'hABCD_0123, 5'd20, 1'b0, 1'b0, 32'hABCD_0123 << 20, 1'b0);
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        send(32'h0000_0003, 5'd2, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
        drain(1'b0);

        // Reset mid-shift discards the operation.
        send(32'hABCD_0123, 5'd20, 1'b1, 1'b1, 32'hFFFF_FABC, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_out_data", obs_out_data, 32'd0);
        chk("midrst_out_valid", {31'd0, obs_out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, obs_busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, obs_in_ready}, 32'd0);
        rst_n = 1'b1;
        tick();

        // STEP = 4 latency and mixed step sizes.
        sel = 2'd2;
        send(32'h0000_00FF, 5'd7, 1'b0, 1'b0, 32'h0000_7F80, 1'b0);
        drain(1'b0);
        send(32'h8000_0000, 5'd13, 1'b1, 1'b1, 32'hFFFC_0000, 1'b0);
        drain(1'b0);

        // Random sweep over all STEP values with random backpressure and flush.
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            for (int k = 0; k < 120; k++) begin
                rd   = $urandom;
                rs   = 5'($urandom_range(0, 31));
                rdir = 1'($urandom_range(0, 1));
                rar  = 1'($urandom_range(0, 1));
                send(rd, rs, rdir, rar, ref_shift(rd, rs, rdir, rar), 1'b1);
                drain(1'b1);
            end
            out_ready = 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
